// File: rtl/stepper_motor.sv
// Stepper motor phase sequencer.
//
// Walks an 8-entry coil phase table at one step every STEP_DIV clocks while a
// motion command is present. Full-step mode strides the table by 2 (wave
// drive, even entries only); half-step mode strides by 1. The coil pattern is
// registered.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   direction  2'b0x stop, 2'b10 forward, 2'b11 reverse (synchronous to clk)
//   q          registered coil drive, q[0] = coil A .. q[3] = coil D
module stepper_motor #(
    parameter int unsigned STEP_DIV  = 1,
    parameter int unsigned HALF_STEP = 0,
    parameter int unsigned HOLD      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] direction,
    output logic [3:0] q
);

    localparam logic [15:0] DivLast  = 16'(STEP_DIV - 1);
    localparam logic [2:0]  StepSize = (HALF_STEP != 0) ? 3'd1 : 3'd2;
    localparam logic [3:0]  RstQ     = (HOLD != 0) ? 4'b0001 : 4'b0000;

    // Adjacent-coil phase table; odd entries energise two neighbouring coils.
    function automatic logic [3:0] phase(input logic [2:0] i);
        logic [3:0] p;
        unique case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  q_q, q_d;
    logic        moving;

    assign moving = direction[1];

    always_comb begin
        idx_d = idx_q;
        cnt_d = 16'd0;
        q_d   = 4'b0000;
        if (moving) begin
            if (cnt_q == DivLast) begin
                // 3-bit arithmetic gives the modulo-8 wrap for free.
                idx_d = direction[0] ? (idx_q - StepSize) : (idx_q + StepSize);
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        // While stopped the divider is cleared so the first step after a
        // restart lands a full STEP_DIV clocks later.
        if (moving || (HOLD != 0)) begin
            q_d = phase(idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 3'd0;
            cnt_q <= 16'd0;
            q_q   <= RstQ;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_stepper_motor.sv
// Directed table-driven bench for stepper_motor. Four instances cover the
// default configuration, half-step, a divided step rate and HOLD=0.
module tb_stepper_motor;

    logic       clk;
    logic       rst_n;
    logic [1:0] dir0, dir1, dir2, dir3;
    logic [3:0] q0, q1, q2, q3;

    int checks;
    int errors;

    stepper_motor u_def (.clk(clk), .rst_n(rst_n), .direction(dir0), .q(q0));
    stepper_motor #(.STEP_DIV(1), .HALF_STEP(1), .HOLD(1))
        u_half (.clk(clk), .rst_n(rst_n), .direction(dir1), .q(q1));
    stepper_motor #(.STEP_DIV(4), .HALF_STEP(0), .HOLD(1))
        u_div4 (.clk(clk), .rst_n(rst_n), .direction(dir2), .q(q2));
    stepper_motor #(.STEP_DIV(1), .HALF_STEP(0), .HOLD(0))
        u_nohold (.clk(clk), .rst_n(rst_n), .direction(dir3), .q(q3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;  // apply reset first, then check the post-reset value
        int         dut;
        logic [1:0] dir;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] q_of(input int d);
        case (d)
            0:       return q0;
            1:       return q1;
            2:       return q2;
            default: return q3;
        endcase
    endfunction

    task automatic set_dir(input int d, input logic [1:0] v);
        case (d)
            0:       dir0 = v;
            1:       dir1 = v;
            2:       dir2 = v;
            default: dir3 = v;
        endcase
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dir0 = 2'b00; dir1 = 2'b00; dir2 = 2'b00; dir3 = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    function automatic void add(input bit r, input int d, input logic [1:0] v,
                                input logic [3:0] e);
        vec_t x;
        x.rst = r; x.dut = d; x.dir = v; x.exp = e;
        vecs.push_back(x);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        dir0 = 2'b00; dir1 = 2'b00; dir2 = 2'b00; dir3 = 2'b00;

        // Default: forward wave drive, reversal, then hold.
        add(1, 0, 2'b00, 4'b0001);
        add(0, 0, 2'b10, 4'b0010);
        add(0, 0, 2'b10, 4'b0100);
        add(0, 0, 2'b10, 4'b1000);
        add(0, 0, 2'b10, 4'b0001);
        add(0, 0, 2'b10, 4'b0010);
        add(0, 0, 2'b11, 4'b0001);
        add(0, 0, 2'b11, 4'b1000);
        add(0, 0, 2'b11, 4'b0100);
        add(0, 0, 2'b11, 4'b0010);
        add(0, 0, 2'b11, 4'b0001);
        add(0, 0, 2'b00, 4'b0001);
        add(0, 0, 2'b01, 4'b0001);
        add(0, 0, 2'b00, 4'b0001);
        // Half-step: full forward lap, then reverse wraps back through 1001.
        add(1, 1, 2'b00, 4'b0001);
        add(0, 1, 2'b10, 4'b0011);
        add(0, 1, 2'b10, 4'b0010);
        add(0, 1, 2'b10, 4'b0110);
        add(0, 1, 2'b10, 4'b0100);
        add(0, 1, 2'b10, 4'b1100);
        add(0, 1, 2'b10, 4'b1000);
        add(0, 1, 2'b10, 4'b1001);
        add(0, 1, 2'b10, 4'b0001);
        add(0, 1, 2'b11, 4'b1001);
        add(0, 1, 2'b11, 4'b1000);
        // STEP_DIV=4: step every 4th edge, stop clears divider, reversal keeps it.
        add(1, 2, 2'b00, 4'b0001);
        add(0, 2, 2'b10, 4'b0001);
        add(0, 2, 2'b10, 4'b0001);
        add(0, 2, 2'b10, 4'b0001);
        add(0, 2, 2'b10, 4'b0010);
        add(0, 2, 2'b10, 4'b0010);
        add(0, 2, 2'b10, 4'b0010);
        add(0, 2, 2'b10, 4'b0010);
        add(0, 2, 2'b10, 4'b0100);
        add(0, 2, 2'b10, 4'b0100);
        add(0, 2, 2'b00, 4'b0100);
        add(0, 2, 2'b10, 4'b0100);
        add(0, 2, 2'b10, 4'b0100);
        add(0, 2, 2'b10, 4'b0100);
        add(0, 2, 2'b10, 4'b1000);
        add(0, 2, 2'b10, 4'b1000);
        add(0, 2, 2'b10, 4'b1000);
        add(0, 2, 2'b11, 4'b1000);
        add(0, 2, 2'b11, 4'b0100);
        // HOLD=0: coils off while stopped, position retained.
        add(1, 3, 2'b00, 4'b0000);
        add(0, 3, 2'b10, 4'b0010);
        add(0, 3, 2'b10, 4'b0100);
        add(0, 3, 2'b00, 4'b0000);
        add(0, 3, 2'b10, 4'b1000);
        add(0, 3, 2'b01, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                @(negedge clk);
                set_dir(vecs[i].dut, vecs[i].dir);
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d_dut%0d", i, vecs[i].dut), q_of(vecs[i].dut), vecs[i].exp);
        end

        // Asynchronous reset between edges while running.
        do_reset();
        @(negedge clk);
        dir0 = 2'b10; dir3 = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        check("async_pre_def", q0, 4'b0100);
        check("async_pre_nohold", q3, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_def", q0, 4'b0001);
        check("async_nohold", q3, 4'b0000);
        @(negedge clk);
        dir0 = 2'b00; dir3 = 2'b00;
        rst_n = 1'b1;

        // Reset mid-step abandons the partial divider count.
        do_reset();
        @(negedge clk);
        dir2 = 2'b10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midstep_in_reset", q2, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("midstep_edge%0d", k), q2, (k == 4) ? 4'b0010 : 4'b0001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
